// File: rtl/latch_close_capture.sv
// latch_close_capture: syncs an async latch gate/data, queues the word seen at each gate close.
// Optional LATCH_CHG_CNT_EN adds a saturating counter of changes between accepted words.
module latch_close_capture #(
  parameter int DATA_W      = 1,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_en,
  input  logic [DATA_W-1:0]        i_d,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ovf,
  input  logic                     i_ovf_clr,
  output logic [7:0]               o_chg_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLOSED, OPEN} state_t;
  logic [SYNC_STAGES-1:0]             en_sync_q;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] d_sync_q;
  logic                               en_s;
  logic [DATA_W-1:0]                  d_s;
  state_t                             state_q, state_d;
  logic                               capture;
  logic [AW:0]                        wr_q, wr_d, rd_q, rd_d;
  logic [DATA_W-1:0]                  mem [DEPTH];
  logic                               empty, full, pop, push_ok, drop;
  logic                               ovf_q, ovf_d;

  assign en_s = en_sync_q[SYNC_STAGES-1];
  assign d_s  = d_sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      en_sync_q <= '0;
      d_sync_q  <= '0;
    end else begin
      en_sync_q <= {en_sync_q[SYNC_STAGES-2:0], i_en};
      d_sync_q  <= {d_sync_q[SYNC_STAGES-2:0], i_d};
    end

  // Gate state simply follows en_s; a close is the OPEN->CLOSED step.
  always_comb begin
    state_d = en_s ? OPEN : CLOSED;
    capture = (state_q == OPEN) && !en_s;
  end

  // Pointers carry an extra wrap bit: equal means empty, MSB-only difference means full.
  always_comb begin
    empty   = wr_q == rd_q;
    full    = (wr_q ^ rd_q) == {1'b1, {AW{1'b0}}};
    pop     = !empty && i_ready;
    push_ok = capture && (!full || pop);
    drop    = capture && !push_ok;
    wr_d    = wr_q + (AW+1)'(push_ok);
    rd_d    = rd_q + (AW+1)'(pop);
    ovf_d   = drop || (ovf_q && !i_ovf_clr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= CLOSED;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ovf_q   <= ovf_d;
    end

  always_ff @(posedge i_clk)
    if (push_ok) mem[wr_q[AW-1:0]] <= d_s;

  assign o_valid = !empty;
  assign o_data  = empty ? '0 : mem[rd_q[AW-1:0]];
  assign o_level = wr_q - rd_q;
  assign o_ovf   = ovf_q;

`ifdef LATCH_CHG_CNT_EN
  logic [DATA_W-1:0] last_q, last_d;
  logic [7:0]        cnt_q, cnt_d;
  always_comb begin
    last_d = push_ok ? d_s : last_q;
    cnt_d  = (push_ok && d_s != last_q && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      last_q <= '0;
      cnt_q  <= '0;
    end else begin
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  assign o_chg_cnt = cnt_q;
`else
  assign o_chg_cnt = '0;
`endif
endmodule

// File: doc/latch_close_capture.md
LATCH_CLOSE_CAPTURE -- requirements
Module: latch_close_capture

Interface
REQ-001 The block SHALL have parameter DATA_W, default 1, giving the width of the latched data word.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the capture FIFO entries; it must be a power of two and at least 2.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer flops per input; it must be at least 2.
REQ-004 i_clk  input  1  SHALL be the single clock; all state is rising-edge.
REQ-005 i_rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 i_en  input  1  SHALL be the upstream latch gate, asynchronous to i_clk.
REQ-007 i_d  input  DATA_W  SHALL be the upstream latch Q output, asynchronous to i_clk.
REQ-008 o_valid  output  1  SHALL mean a captured word is available at o_data.
REQ-009 i_ready  input  1  SHALL mean the consumer accepts o_data this cycle.
REQ-010 o_data  output  DATA_W  SHALL be the oldest captured word.
REQ-011 o_level  output  log2(DEPTH)+1  SHALL be the FIFO occupancy.
REQ-012 o_ovf  output  1  SHALL be the sticky flag for a dropped capture.
REQ-013 i_ovf_clr  input  1  SHALL be the synchronous clear for o_ovf.
REQ-014 o_chg_cnt  output  8  SHALL be the saturating count of captured value changes.

Function
REQ-015 i_en and i_d SHALL each pass through a SYNC_STAGES-flop synchronizer, producing en_s and d_s; no other logic shall use the raw inputs.
REQ-016 The tracking FSM SHALL have two states:
- CLOSED to OPEN when en_s=1.
- OPEN to CLOSED when en_s=0, asserting a one-cycle capture pulse in the same cycle.
- No other transitions.
REQ-017 The capture pulse SHALL push the d_s value of that cycle into the FIFO.
REQ-018 Latency from an i_en falling edge to o_valid=1 SHALL be SYNC_STAGES+1 cycles when the FIFO is empty.
REQ-019 o_valid SHALL equal "FIFO not empty"; o_data SHALL be the head entry and SHALL be stable while o_valid=1 and i_ready=0.
REQ-020 A pop SHALL occur when o_valid=1 and i_ready=1; i_ready with the FIFO empty SHALL have no effect.
REQ-021 A push SHALL be accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
REQ-022 Otherwise the push SHALL be dropped, the FIFO contents SHALL be unchanged, and o_ovf SHALL set on the next edge.
REQ-023 Simultaneous push and pop SHALL leave o_level unchanged.
REQ-024 FIFO pointers SHALL be log2(DEPTH)+1 bits and SHALL wrap modulo 2*DEPTH; full/empty SHALL derive from the MSB comparison.
REQ-025 When i_ovf_clr=1 in the same cycle as a new drop, o_ovf SHALL remain 1 (set wins).
REQ-026 An en_s pulse that opens and closes SHALL produce exactly one capture; an en_s pulse shorter than one synchronized sample MAY be missed, and this is not an error.

Reset
REQ-027 Asserting i_rst_n=0 SHALL immediately force the following, regardless of the clock:
- FSM to CLOSED
- synchronizer flops to 0
- FIFO empty
- o_valid=0, o_data=0, o_level=0, o_ovf=0, o_chg_cnt=0
REQ-028 Reset mid-operation SHALL discard all queued words and any in-flight capture.
REQ-029 If en_s=1 on the first cycle after reset release, the FSM SHALL go to OPEN with no capture.

Configuration
REQ-030 With macro LATCH_CHG_CNT_EN defined, o_chg_cnt SHALL increment by 1 on each accepted push whose word differs from the previous accepted word.
- The first push after reset compares against 0.
- The count saturates at 255.
- Dropped pushes do not count.
REQ-031 Without LATCH_CHG_CNT_EN, o_chg_cnt SHALL be constant 0, no counter or compare register SHALL exist, and the port SHALL remain present.

Verification
REQ-032 The bench SHALL cover these directed scenarios (DATA_W=1, DEPTH=4, SYNC_STAGES=2):
- Scenario 1: i_d=1, i_en pulsed high for 5 cycles then low, i_ready=0 -> o_valid=1 exactly 3 cycles after the fall, o_data=1, o_level=1.
- Scenario 2: 5 close events, i_ready=0 -> o_level=4, o_ovf=1, o_data equals the first word; assert i_ovf_clr -> o_ovf=0.
- Scenario 3: FIFO full, then a close event in the same cycle as i_ready=1 -> push accepted, o_level stays 4, o_ovf stays 0.
- Scenario 4: captured sequence 1,1,0,1 with LATCH_CHG_CNT_EN defined -> o_chg_cnt=3; same sequence without the macro -> o_chg_cnt=0.
- Scenario 5: i_rst_n pulsed low with o_level=2 and i_en high -> all outputs 0 immediately; after release with i_en still high, no capture until i_en falls.
- Scenario 6: 300 alternating captures with continuous i_ready=1 -> o_chg_cnt saturates at 255 and o_ovf stays 0.
